// File: rtl/run_pattern_pkg.sv
// run_pattern_pkg: state encodings, defaults and detector match level shared by the pattern transmitter
package run_pattern_pkg;
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_SEND = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;
   localparam int WIDTH_DEF = 16;
   localparam int RUN_LEN_DEF = 4;
   localparam logic Z_MATCH = 1'b1;
endpackage

// File: rtl/run_pattern_tx_run_len_model.sv
// run_len_model: registered reference of the run-length detector output, one cycle behind each valid bit
module run_len_model
   import run_pattern_pkg::*;
#(
   parameter int RUN_LEN = RUN_LEN_DEF,
   parameter int LW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          bit_i,
   input  logic          valid_i,
   input  logic          clear_i,
   output logic [LW-1:0] run_cnt_o,
   output logic          expect_z_o
);
   logic          prev_q;
   logic [LW-1:0] cnt_d;
   // A zero count marks the first bit of a frame, so it always restarts the run
   always_comb cnt_d = (run_cnt_o != '0 && bit_i == prev_q)
                     ? ((run_cnt_o == LW'(RUN_LEN)) ? run_cnt_o : run_cnt_o + 1'b1)
                     : LW'(1);
   always_ff @(posedge clk)
      if (!rst || clear_i) begin
         run_cnt_o  <= '0;
         prev_q     <= 1'b0;
         expect_z_o <= ~Z_MATCH;
      end else if (valid_i) begin
         run_cnt_o  <= cnt_d;
         prev_q     <= bit_i;
         expect_z_o <= (cnt_d == LW'(RUN_LEN)) ? Z_MATCH : ~Z_MATCH;
      end
endmodule

// File: rtl/run_pattern_tx.sv
// run_pattern_tx: shifts a captured pattern out LSB-first with framing strobes and a detector reference model
module run_pattern_tx
   import run_pattern_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RUN_LEN = RUN_LEN_DEF,
   localparam int LW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LW-1:0]    len,
   output logic             w_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic             expect_z,
   output logic [LW-1:0]    run_cnt
);
   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [LW-1:0]    cnt_q, cnt_d, len_c;
   logic             w_d, capture;
   assign len_c   = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
   assign capture = (state_q == ST_IDLE) && start;
   // The first bit leaves on the capture edge; cnt holds the bits still to send after the one on w_out
   always_comb begin
      state_d = ST_IDLE;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      w_d     = 1'b0;
      if (capture) begin
         state_d = (len_c != '0) ? ST_SEND : ST_DONE;
         w_d     = pattern[0] & (len_c != '0);
         sr_d    = pattern >> 1;
         cnt_d   = (len_c != '0) ? len_c - 1'b1 : '0;
      end else if (state_q == ST_SEND) begin
         state_d = (cnt_q != '0) ? ST_SEND : ST_DONE;
         w_d     = sr_q[0] & (cnt_q != '0);
         sr_d    = sr_q >> 1;
         cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      end
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state_q   <= ST_IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         w_out     <= 1'b0;
         bit_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         w_out     <= w_d;
         bit_valid <= state_d == ST_SEND;
         busy      <= state_d != ST_IDLE;
         done      <= state_d == ST_DONE;
      end
   run_len_model #(.RUN_LEN(RUN_LEN), .LW(LW)) u_model (
      .clk       (clk),
      .rst       (rst),
      .bit_i     (w_out),
      .valid_i   (bit_valid),
      .clear_i   (capture),
      .run_cnt_o (run_cnt),
      .expect_z_o(expect_z)
   );
endmodule

// File: doc/run_pattern_tx.md
Name: run_pattern_tx

Overview:
Serial pattern transmitter. It is the driving end of the run-length sequence detector interface already in the design.
- Loads a parallel pattern word and shifts it out LSB-first on the single-bit line w_out, one bit per clk.
- Keeps a registered reference model (expect_z) of the detector output: high when the last RUN_LEN emitted bits are all 0 or all 1.
- Used on-board to feed the detector's w input from switches, and in benches as the stimulus and scoreboard source.

Parameters:
- WIDTH, 16: maximum pattern length in bits (>=2).
- RUN_LEN, 4: run length that asserts expect_z (2..WIDTH).
- LW, $clog2(WIDTH+1): width of len port (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request a frame; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; bit 0 goes first.
- len  input  LW  number of bits to send, 0..WIDTH; values >WIDTH clamp to WIDTH.
- w_out  output  1  serial data, to the detector's w input.
- bit_valid  output  1  high on every cycle w_out carries a frame bit.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse at end of frame.
- expect_z  output  1  modelled detector output.
- run_cnt  output  LW  current identical-bit run length, saturating at RUN_LEN (debug).

Behaviour:
- Reset (rst=0 at a clk edge), regardless of state:
  - state=IDLE.
  - w_out, bit_valid, busy, done, expect_z = 0; run_cnt = 0.
  - Shift register and bit counter cleared.
- Registers and outputs: all registered. No combinational path from start or pattern to any output.
- State machine IDLE, SEND, DONE, binary encoded 2'b00, 2'b01, 2'b10. The illegal code 2'b11 goes to IDLE.
- IDLE:
  - w_out=0, bit_valid=0.
  - On start=1 at edge t: capture pattern into the shift register, capture clamped len into the counter, clear run_cnt and expect_z.
  - Next state SEND if len>0, else DONE.
- SEND:
  - Bit i of pattern appears on w_out with bit_valid=1 during cycle t+1+i, for i = 0..len-1.
  - The shift register moves right one bit per cycle.
  - After the last bit, next state is DONE.
- DONE: exactly one cycle.
  - Cycle t+1+len (t+1 when len=0): done=1, bit_valid=0, w_out=0.
  - Next state IDLE.
  - A new start is accepted from the following cycle. Minimum frame-to-frame spacing is len+2 cycles.
- start while busy: ignored, not queued. pattern and len are don't-care outside the capture edge.
- Run model (updates at the edge ending each cycle where bit_valid=1):
  - If bit equals the previous emitted bit and this is not the first bit of the frame: run_cnt = min(run_cnt+1, RUN_LEN).
  - Otherwise run_cnt = 1.
  - expect_z <= (new run_cnt == RUN_LEN).
  - Alignment: expect_z is valid one cycle after the bit, matching the detector's registered state output.
- expect_z holds its value through DONE and IDLE. It is cleared only by start capture or reset.
- busy=1 exactly when state is SEND or DONE.
- Reset mid-frame: the frame is abandoned with no done pulse. w_out returns to 0 on the next cycle.

Decomposition:
- Shared package run_pattern_pkg:
  - state encodings ST_IDLE, ST_SEND, ST_DONE.
  - defaults WIDTH_DEF=16, RUN_LEN_DEF=4.
  - detector match level constant Z_MATCH=1'b1.
- One natural sub-module, run_len_model: bit input, valid input, frame-start clear; outputs run_cnt and expect_z. The detector bench can reuse it as its scoreboard.
- The shifter, counter and FSM stay in the top module.

Test Plan (WIDTH=16, RUN_LEN=4, start pulsed at cycle 0):
1. Reset: rst=0 for 2 cycles mid-SEND of pattern=16'hFFFF, len=16 -> next cycle all outputs 0, state IDLE, no done pulse.
2. pattern=16'h000F, len=8 -> w_out=1,1,1,1,0,0,0,0 on cycles 1..8 with bit_valid=1. expect_z=1 on cycle 5, 0 on cycles 6..8, 1 on cycle 9. done=1 only on cycle 9. busy=1 on cycles 1..9.
3. pattern=16'h5555, len=16 -> alternating bits. run_cnt stays 1, expect_z stays 0 throughout. done on cycle 17.
4. len=0 -> no bit_valid. done on cycle 1, busy only on cycle 1. New start on cycle 2 is accepted and first bit appears on cycle 3.
5. pattern=16'h003F, len=6, second start at cycle 3 with pattern=16'h0 -> second start ignored. Six 1s sent; expect_z=1 on cycles 5..7, then held 1 in IDLE.
6. len=31 (>WIDTH), pattern=16'h0000 -> clamped to 16 bits. expect_z rises on cycle 5 and stays 1. done on cycle 17.
